// File: rtl/intersection_ctrl.sv
// Phase sequencer for a four-signal intersection: MAIN by default, latched turn/ped
// requests served after a minimum main green, all-red clearance between greens.
// Optional build macro TURN_EXTEND_EN: turn phase extends while turn_sensor stays high.
module intersection_ctrl #(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned TURN_TIME  = 6,
  parameter int unsigned TURN_MAX   = 12,
  parameter int unsigned PED_TIME   = 10,
  parameter int unsigned CLEAR_TIME = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pedestrian_button,
  input  logic turn_sensor,
  output logic pedestrian_green,
  output logic up_green,
  output logic down_green,
  output logic turn_green
);

  localparam logic [1:0] ST_CLR  = 2'd0;
  localparam logic [1:0] ST_MAIN = 2'd1;
  localparam logic [1:0] ST_TURN = 2'd2;
  localparam logic [1:0] ST_PED  = 2'd3;

  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TIME - 1);
  localparam logic [CNT_W-1:0] PED_LAST   = CNT_W'(PED_TIME - 1);
`ifdef TURN_EXTEND_EN
  localparam logic [CNT_W-1:0] TURN_CAP   = CNT_W'(TURN_MAX - 1);
`endif

  // Elaboration-time guard on the timing parameters
  if (TURN_MAX < TURN_TIME || MIN_GREEN == 0 || TURN_TIME == 0 || PED_TIME == 0 ||
      CLEAR_TIME == 0 || TURN_MAX >= (2 ** CNT_W) || MIN_GREEN >= (2 ** CNT_W) ||
      PED_TIME >= (2 ** CNT_W) || CLEAR_TIME >= (2 ** CNT_W)) begin : g_param_check
    $error("intersection_ctrl: illegal timing parameters");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       target_q, target_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_req_q, ped_req_d;
  logic             turn_req_q, turn_req_d;
  logic             ped_green_q, ped_green_d;
  logic             up_green_q, up_green_d;
  logic             down_green_q, down_green_d;
  logic             turn_green_q, turn_green_d;
  logic             turn_done;

`ifdef TURN_EXTEND_EN
  assign turn_done = ((timer_q >= TURN_LAST) && !turn_sensor) || (timer_q == TURN_CAP);
`else
  assign turn_done = (timer_q == TURN_LAST);
`endif

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    ped_req_d    = ped_req_q;
    turn_req_d   = turn_req_q;
    timer_d      = (timer_q == TIMER_MAX) ? timer_q : timer_q + CNT_W'(1);
    ped_green_d  = 1'b0;
    up_green_d   = 1'b0;
    down_green_d = 1'b0;
    turn_green_d = 1'b0;

    case (state_q)
      ST_CLR: begin
        if (timer_q == CLEAR_LAST) state_d = target_q;
      end
      ST_MAIN: begin
        if ((timer_q >= MIN_LAST) && (turn_req_q || ped_req_q)) begin
          state_d  = ST_CLR;
          target_d = turn_req_q ? ST_TURN : ST_PED;
        end
      end
      ST_TURN: begin
        if (turn_done) begin
          state_d  = ST_CLR;
          target_d = ped_req_q ? ST_PED : ST_MAIN;
        end
      end
      ST_PED: begin
        if (timer_q == PED_LAST) begin
          state_d  = ST_CLR;
          target_d = ST_MAIN;
        end
      end
      default: begin
        state_d  = ST_CLR;
        target_d = ST_MAIN;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // Requests latch outside their own phase; the entering edge's clear wins
    if (pedestrian_button && (state_q != ST_PED)) ped_req_d = 1'b1;
    if ((state_d == ST_PED) && (state_q != ST_PED)) ped_req_d = 1'b0;
    if (turn_sensor && (state_q != ST_TURN)) turn_req_d = 1'b1;
    if ((state_d == ST_TURN) && (state_q != ST_TURN)) turn_req_d = 1'b0;

    case (state_d)
      ST_MAIN: begin
        up_green_d   = 1'b1;
        down_green_d = 1'b1;
      end
      ST_TURN: begin
        up_green_d   = 1'b1;
        turn_green_d = 1'b1;
      end
      ST_PED:  ped_green_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLR;
      target_q     <= ST_MAIN;
      timer_q      <= '0;
      ped_req_q    <= 1'b0;
      turn_req_q   <= 1'b0;
      ped_green_q  <= 1'b0;
      up_green_q   <= 1'b0;
      down_green_q <= 1'b0;
      turn_green_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      timer_q      <= timer_d;
      ped_req_q    <= ped_req_d;
      turn_req_q   <= turn_req_d;
      ped_green_q  <= ped_green_d;
      up_green_q   <= up_green_d;
      down_green_q <= down_green_d;
      turn_green_q <= turn_green_d;
    end
  end

  assign pedestrian_green = ped_green_q;
  assign up_green         = up_green_q;
  assign down_green       = down_green_q;
  assign turn_green       = turn_green_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: stimulus queues per-cycle expected light
// patterns {ped, up, down, turn}; a negedge monitor pops and compares them.
module tb_intersection_ctrl;

  localparam logic [3:0] P_CLR  = 4'b0000;
  localparam logic [3:0] P_MAIN = 4'b0110;
  localparam logic [3:0] P_TURN = 4'b0101;
  localparam logic [3:0] P_PED  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] pat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pedestrian_button = 1'b0;
  logic turn_sensor = 1'b0;
  logic pedestrian_green, up_green, down_green, turn_green;

  exp_t q[$];
  int   cyc = 0;
  int   exp_cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   r;

  intersection_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .pedestrian_button(pedestrian_button),
    .turn_sensor      (turn_sensor),
    .pedestrian_green (pedestrian_green),
    .up_green         (up_green),
    .down_green       (down_green),
    .turn_green       (turn_green)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: scheduled comparison plus the safety invariants every cycle
  always @(negedge clock) begin
    logic [3:0] act;
    exp_t       e;
    act = {pedestrian_green, up_green, down_green, turn_green};
    if (q.size() > 0) begin
      if (q[0].cyc < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_check cyc=%0d required=%b", e.cyc, e.pat);
      end else if (q[0].cyc == cyc) begin
        e = q.pop_front();
        total++;
        if (act !== e.pat) begin
          bad++;
          $display("FAIL lights cyc=%0d actual=%b required=%b", cyc, act, e.pat);
        end
      end
    end
    total++;
    if ((pedestrian_green && (up_green || down_green)) || (turn_green && down_green) ||
        (turn_green && !up_green)) begin
      bad++;
      $display("FAIL invariant cyc=%0d actual=%b", cyc, act);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back('{exp_cyc, p});
      exp_cyc++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      $fatal(1, "scoreboard stuck");
    end
  endtask

  task automatic do_reset(output int rel);
    pedestrian_button = 1'b0;
    turn_sensor       = 1'b0;
    reset             = 1'b1;
    wait_cyc(cyc + 2);
    reset   = 1'b0;
    rel     = cyc;
    exp_cyc = cyc;
  endtask

  // Drive inputs high for the single edge at cycle at+1
  task automatic pulse(input logic ped, input logic trn, input int at);
    wait_cyc(at);
    pedestrian_button = ped;
    turn_sensor       = trn;
    wait_cyc(at + 1);
    pedestrian_button = 1'b0;
    turn_sensor       = 1'b0;
  endtask

  initial begin
    // Reset, release, idle main green
    wait_cyc(2);
    exp_cyc = 2;
    push(P_CLR, 3);
    push(P_MAIN, 100);
    wait_cyc(3);
    reset = 1'b0;
    drain();

    // Pedestrian press in MAIN cycle 3
    do_reset(r);
    push(P_CLR, 2); push(P_MAIN, 8); push(P_CLR, 2); push(P_PED, 10);
    push(P_CLR, 2); push(P_MAIN, 20);
    pulse(1'b1, 1'b0, r + 4);
    drain();

    // Turn and pedestrian together: turn first, then ped, then main
    do_reset(r);
    push(P_CLR, 2); push(P_MAIN, 8); push(P_CLR, 2); push(P_TURN, 6);
    push(P_CLR, 2); push(P_PED, 10); push(P_CLR, 2); push(P_MAIN, 10);
    pulse(1'b1, 1'b1, r + 4);
    drain();

    // Reset mid-PED with turn pending: async drop, turn request lost
    do_reset(r);
    push(P_CLR, 2); push(P_MAIN, 8); push(P_CLR, 2); push(P_PED, 3);
    push(P_CLR, 4); push(P_MAIN, 20);
    pulse(1'b1, 1'b0, r + 4);
    pulse(1'b0, 1'b1, r + 13);
    wait_cyc(r + 15);
    #2;
    reset = 1'b1;
    wait_cyc(r + 17);
    reset = 1'b0;
    drain();

`ifdef TURN_EXTEND_EN
    // Sensor held through TURN: capped at TURN_MAX
    do_reset(r);
    push(P_CLR, 2); push(P_MAIN, 8); push(P_CLR, 2); push(P_TURN, 12);
    push(P_CLR, 2); push(P_MAIN, 10);
    wait_cyc(r + 4);
    turn_sensor = 1'b1;
    wait_cyc(r + 24);
    turn_sensor = 1'b0;
    drain();

    // Sensor dropped in TURN cycle 8
    do_reset(r);
    push(P_CLR, 2); push(P_MAIN, 8); push(P_CLR, 2); push(P_TURN, 8);
    push(P_CLR, 2); push(P_MAIN, 10);
    wait_cyc(r + 4);
    turn_sensor = 1'b1;
    wait_cyc(r + 19);
    turn_sensor = 1'b0;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
